// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion definitions: round count, first round
// constant, controller state encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } state_t;

  // Multiply by x in GF(2^8): shift left, reduce by 0x1B on carry-out
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box lookup.
module aes_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out = SBOX[in];

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key-expansion controller: one shared S-box substitutes the four
// bytes of RotWord(w3) over four SUB cycles, then a MIX cycle produces the
// next round key. All eleven round keys are held for combinational readout.
module key_expansion_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  state_t       state;
  state_t       state_next;
  logic [3:0]   round;
  logic [1:0]   byte_idx;
  logic [7:0]   rcon;
  logic [31:0]  temp;
  logic [127:0] rk [0:10];

  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [31:0]  g_word;
  logic [31:0]  w0n, w1n, w2n, w3n;

  // Previous round key (rk[round-1]) feeds both the S-box and the MIX step
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 11; i++) begin
      if (round == 4'(i + 1)) prev_key = rk[i];
    end
  end

  // Pick the byte of RotWord(w3) for this SUB cycle, MSB first
  always_comb begin
    rot_word = {prev_key[23:0], prev_key[31:24]};
    sbox_in  = 8'h00;
    case (byte_idx)
      2'd0: sbox_in = rot_word[31:24];
      2'd1: sbox_in = rot_word[23:16];
      2'd2: sbox_in = rot_word[15:8];
      2'd3: sbox_in = rot_word[7:0];
      default: sbox_in = 8'h00;
    endcase
  end

  aes_sbox u_sbox (
    .in  (sbox_in),
    .out (sbox_out)
  );

  // XOR chain forming the next round key from temp and the previous key
  always_comb begin
    g_word = temp ^ {rcon, 24'h0};
    w0n    = prev_key[127:96] ^ g_word;
    w1n    = prev_key[95:64]  ^ w0n;
    w2n    = prev_key[63:32]  ^ w1n;
    w3n    = prev_key[31:0]   ^ w2n;
  end

  // Round-key read port; out-of-range indices read as zero
  always_comb begin
    rk_data = '0;
    for (int i = 0; i < 11; i++) begin
      if (rk_addr == 4'(i)) rk_data = rk[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state;
    ready      = (state == IDLE);
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_next = SUB;
      SUB:  if (byte_idx == 2'd3) state_next = MIX;
      MIX:  state_next = (round == 4'(NR)) ? IDLE : SUB;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: key capture, byte substitution, round-key write, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round      <= 4'd0;
      byte_idx   <= 2'd0;
      rcon       <= RCON_INIT;
      temp       <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk[0]      <= cipher_key;
            round      <= 4'd1;
            byte_idx   <= 2'd0;
            rcon       <= RCON_INIT;
            keys_valid <= 1'b0;
          end
        end
        SUB: begin
          case (byte_idx)
            2'd0: temp[31:24] <= sbox_out;
            2'd1: temp[23:16] <= sbox_out;
            2'd2: temp[15:8]  <= sbox_out;
            2'd3: temp[7:0]   <= sbox_out;
            default: temp     <= temp;
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
        MIX: begin
          for (int i = 1; i < 11; i++) begin
            if (round == 4'(i)) rk[i] <= {w0n, w1n, w2n, w3n};
          end
          if (round == 4'(NR)) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end else begin
            round <= round + 4'd1;
            rcon  <= xtime(rcon);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
